// File: rtl/instr_fetch_issue_if.sv
// Bundle of the fetch front end's memory, issue and branch-resolution handshakes.
// The fetch unit is the master; memory, control unit and execute stage sit on the slave side.
interface instr_fetch_issue_if;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_data;
   logic        instr_valid;
   logic        instr_ready;
   logic [5:0]  opcode;
   logic [4:0]  rs;
   logic [4:0]  rt;
   logic [4:0]  rd;
   logic [4:0]  shamt;
   logic [5:0]  func;
   logic [15:0] imm;
   logic [31:0] pc_out;
   logic        br_valid;
   logic        br_taken;
   logic        br_wait;

   modport master (
      output imem_req, imem_addr, instr_valid, opcode, rs, rt, rd, shamt, func, imm, pc_out, br_wait,
      input  imem_ack, imem_data, instr_ready, br_valid, br_taken
   );

   modport slave (
      input  imem_req, imem_addr, instr_valid, opcode, rs, rt, rd, shamt, func, imm, pc_out, br_wait,
      output imem_ack, imem_data, instr_ready, br_valid, br_taken
   );
endinterface

// File: rtl/instr_fetch_issue.sv
// Fetch-and-issue front end: fetches one word at a time, presents its MIPS fields,
// and stalls on bne until the execute stage reports the outcome.
module instr_fetch_issue #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter logic [5:0]  BNE_OPCODE = 6'b000101
) (
   input  logic                   i_clk,
   input  logic                   i_rst,
   input  logic                   i_en,
   instr_fetch_issue_if.master    io_bus
);

   typedef enum logic [1:0] {
      IDLE,
      FETCH,
      ISSUE,
      BRWAIT
   } state_t;

   state_t      r_state;
   state_t      w_nextState;
   logic [31:0] r_pc;
   logic [31:0] w_nextPc;
   logic [31:0] r_instr;
   logic        w_loadInstr;
   logic [31:0] w_pcPlus4;
   logic [31:0] w_brTarget;
   logic        w_imemReq;
   logic        w_instrValid;
   logic        w_brWait;

   assign w_pcPlus4  = r_pc + 32'd4;
   assign w_brTarget = w_pcPlus4 + {{14{r_instr[15]}}, r_instr[15:0], 2'b00};

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state <= IDLE;
         r_pc    <= RESET_PC;
         r_instr <= 32'd0;
      end else begin
         r_state <= w_nextState;
         r_pc    <= w_nextPc;
         if (w_loadInstr) begin
            r_instr <= io_bus.imem_data;
         end
      end
   end

   // The PC only moves when an instruction retires from ISSUE or a branch resolves.
   always_comb begin
      w_nextState  = r_state;
      w_nextPc     = r_pc;
      w_loadInstr  = 1'b0;
      w_imemReq    = 1'b0;
      w_instrValid = 1'b0;
      w_brWait     = 1'b0;
      case (r_state)
         IDLE: begin
            if (i_en) begin
               w_nextState = FETCH;
            end
         end
         FETCH: begin
            w_imemReq = 1'b1;
            if (io_bus.imem_ack) begin
               w_loadInstr = 1'b1;
               w_nextState = ISSUE;
            end
         end
         ISSUE: begin
            w_instrValid = 1'b1;
            if (io_bus.instr_ready) begin
               if (r_instr[31:26] == BNE_OPCODE) begin
                  w_nextState = BRWAIT;
               end else begin
                  w_nextPc    = w_pcPlus4;
                  w_nextState = i_en ? FETCH : IDLE;
               end
            end
         end
         BRWAIT: begin
            w_brWait = 1'b1;
            if (io_bus.br_valid) begin
               w_nextPc    = io_bus.br_taken ? w_brTarget : w_pcPlus4;
               w_nextState = i_en ? FETCH : IDLE;
            end
         end
         default: begin
            w_nextState = IDLE;
         end
      endcase
   end

   assign io_bus.imem_req    = w_imemReq;
   assign io_bus.imem_addr   = r_pc;
   assign io_bus.instr_valid = w_instrValid;
   assign io_bus.br_wait     = w_brWait;
   assign io_bus.pc_out      = r_pc;
   assign io_bus.opcode      = r_instr[31:26];
   assign io_bus.rs          = r_instr[25:21];
   assign io_bus.rt          = r_instr[20:16];
   assign io_bus.rd          = r_instr[15:11];
   assign io_bus.shamt       = r_instr[10:6];
   assign io_bus.func        = r_instr[5:0];
   assign io_bus.imm         = r_instr[15:0];

endmodule
